// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vec_pkg
// Purpose : Shared constants and enums for the vector load/store sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package vec_pkg;

   localparam int VLEN = 16;
   localparam int EW   = 16;
   localparam int AW   = 16;
   localparam int RAW  = 3;
   localparam int CW   = 4;

   localparam logic [CW-1:0] CNT_LAST = CW'(VLEN - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(VLEN - 2);

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_XFER  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/vec_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : vec_addr_gen
// Purpose : Element address accumulator; VEC_STRIDE_EN adds a latched stride,
//           otherwise the stride is fixed at one.
// Revision: 1.0 - initial release
// ============================================================================
module vec_addr_gen
   import vec_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [AW-1:0] base_i,
`ifdef VEC_STRIDE_EN
   input  logic [AW-1:0] stride_i,
`endif
   output logic [AW-1:0] addr_o
);

   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_d;
   logic [AW-1:0] w_stride;

`ifdef VEC_STRIDE_EN
   logic [AW-1:0] stride_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stride_q <= '0;
      end else if (load_i) begin
         stride_q <= stride_i;
      end
   end

   assign w_stride = stride_q;
`else
   assign w_stride = AW'(1);
`endif

   // The base is folded into the accumulator on load; wrap is modulo 2^AW.
   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = base_i;
      end else if (step_i) begin
         addr_d = addr_q + w_stride;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule
`default_nettype wire

// File: rtl/vec_mem_seq.sv
`default_nettype none
// ============================================================================
// Module  : vec_mem_seq
// Purpose : Load/store sequencer between data memory and the vector RF serial
//           port. Optional macro VEC_STRIDE_EN adds the Stride input.
// Revision: 1.0 - initial release
// ============================================================================
module vec_mem_seq
   import vec_pkg::*;
(
   input  logic           Clk,
   input  logic           Rst,
   input  logic           Start,
   input  logic           Op,
   input  logic [RAW-1:0] VecIdx,
   input  logic [AW-1:0]  MemBase,
`ifdef VEC_STRIDE_EN
   input  logic [AW-1:0]  Stride,
`endif
   output logic           Busy,
   output logic           Done,
   output logic [RAW-1:0] RfAddr,
   output logic           RfWr_s,
   output logic           RfRd_s,
   output logic [EW-1:0]  RfDataIn_s,
   input  logic [EW-1:0]  RfDataOut_s,
   output logic [AW-1:0]  MemAddr,
   output logic           MemRd,
   input  logic [EW-1:0]  MemRdData,
   output logic           MemWr,
   output logic [EW-1:0]  MemWrData
);

   state_e         state_q;
   op_e            op_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;
   logic           done_q;
   logic           rfwr_q;
   logic           rfrd_q;
   logic           memrd_q;
   logic           memwr_q;
   logic [RAW-1:0] rfaddr_q;
   logic           w_load;
   logic           w_step;

   assign w_load = (state_q == S_IDLE) && Start;

   // Load prefetches one element ahead; store writes trail the RF read by one.
   assign w_step = ((state_q == S_SETUP) && (op_q == OP_LOAD)) ||
                   ((state_q == S_XFER) && (op_q == OP_LOAD)  && (cnt_q != CNT_LAST)) ||
                   ((state_q == S_XFER) && (op_q == OP_STORE) && (cnt_q != '0));

   vec_addr_gen u_addr_gen (
      .clk_i    (Clk),
      .rst_i    (Rst),
      .load_i   (w_load),
      .step_i   (w_step),
      .base_i   (MemBase),
`ifdef VEC_STRIDE_EN
      .stride_i (Stride),
`endif
      .addr_o   (MemAddr)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_LOAD;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rfwr_q   <= 1'b0;
         rfrd_q   <= 1'b0;
         memrd_q  <= 1'b0;
         memwr_q  <= 1'b0;
         rfaddr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  state_q  <= S_SETUP;
                  op_q     <= op_e'(Op);
                  rfaddr_q <= VecIdx;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  memrd_q  <= (op_e'(Op) == OP_LOAD);
               end
            end
            S_SETUP: begin
               state_q <= S_XFER;
               cnt_q   <= '0;
               rfwr_q  <= (op_q == OP_LOAD);
               rfrd_q  <= (op_q == OP_STORE);
            end
            S_XFER: begin
               cnt_q <= cnt_q + 1'b1;
               if (op_q == OP_LOAD) begin
                  memrd_q <= (cnt_q < CNT_PRE);
                  if (cnt_q == CNT_LAST) begin
                     rfwr_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end else begin
                  memwr_q <= 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     rfrd_q  <= 1'b0;
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               memwr_q <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Busy       = busy_q;
   assign Done       = done_q;
   assign RfAddr     = rfaddr_q;
   assign RfWr_s     = rfwr_q;
   assign RfRd_s     = rfrd_q;
   assign MemRd      = memrd_q;
   assign MemWr      = memwr_q;
   assign RfDataIn_s = rfwr_q  ? MemRdData   : '0;
   assign MemWrData  = memwr_q ? RfDataOut_s : '0;

endmodule
`default_nettype wire
